// File: rtl/shift_serializer.sv
// Parallel-to-serial front end for an 8-bit serial-in shift register.
// Buffers one word and emits it as a serial bit plus a shift strobe, with optional inter-word gap.
module shift_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             ser_data,
    output logic             ser_shift_en,
    output logic             word_done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   buf_data;
    logic               buf_full;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               accept;
    logic               load;
    logic               gap_done;

    // Handshake: a word transfers on any rising edge where in_valid && in_ready.
    // in_ready is pure registered state, so there is no in_valid -> in_ready path.
    assign in_ready  = !buf_full;
    assign accept    = in_valid && !buf_full;
    assign busy      = (state != IDLE) || buf_full;
    assign state_dbg = state;
    assign gap_done  = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        ser_shift_en = 1'b0;
        ser_data     = 1'b0;
        word_done    = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_shift_en = !hold;
                ser_data     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                word_done    = !hold && (bit_cnt == CNT_W'(WIDTH - 1));
                if (word_done) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                    end else if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (buf_full) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            buf_data <= '0;
            buf_full <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            state <= state_nxt;
            // accept needs an empty buffer and load needs a full one, so they never coincide
            if (accept) begin
                buf_data <= in_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            if (load) begin
                shreg   <= buf_data;
                bit_cnt <= '0;
            end else if (ser_shift_en) begin
                shreg   <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (state == GAP) begin
                gap_cnt <= gap_done ? '0 : gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule
